keypad_emulator: RTL and testbench

- Synthesizable responder for the 4x4 matrix-keypad interface: it plays the role of the physical keypad.
- It watches the one-hot column strobes from a keypad scanner and drives the row lines exactly as a pressed switch would.
- Presses are requested through a valid/ready command port; each press includes contact bounce on make and break.
- Used for closed-loop board self-test and simulation of the keypad scanner without a physical keypad.

---
 rtl/keypad_emulator.sv | 167 ++++++++++++++++
 tb/tb_keypad_emulator.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - 4x4 matrix keypad responder with contact bounce, driven by press commands
module keypad_emulator #(
    parameter int BOUNCE_CYCLES = 4,
    parameter int HOLD_SCANS    = 2,
    parameter int TIMEOUT       = 1048575
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       press_valid,
    input  logic [3:0] press_key,
    output logic       press_ready,
    input  logic [3:0] col,
    output logic [3:0] filas,
    output logic       busy,
    output logic       done,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BOUNCE_IN,
        S_HOLD,
        S_BOUNCE_OUT
    } state_t;

    localparam int          HOLD_EFF    = (HOLD_SCANS == 0) ? 1 : HOLD_SCANS;
    localparam logic [15:0] SCANS_NEED  = 16'(HOLD_EFF);
    localparam logic [15:0] BOUNCE_LAST = 16'(BOUNCE_CYCLES - 1);
    localparam logic [19:0] HOLD_LAST   = 20'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [3:0]  key_col_q, key_col_d;
    logic [3:0]  key_row_q, key_row_d;
    logic [3:0]  col_prev_q, col_prev_d;
    logic [15:0] bounce_cnt_q, bounce_cnt_d;
    logic [19:0] hold_cyc_q, hold_cyc_d;
    logic [15:0] scan_cnt_q, scan_cnt_d;
    logic        ready_q, done_q, done_d, timeout_q, timeout_d;
    logic [3:0]  col_hit;
    logic        col_edge;
    logic        contact;
    logic [7:0]  key_map;

    // Upper nibble is the column strobe the key answers to, lower nibble its row line.
    function automatic logic [7:0] key_lookup(input logic [3:0] code);
        case (code)
            4'h1:    key_lookup = 8'b1000_1000;
            4'h2:    key_lookup = 8'b1000_0100;
            4'h3:    key_lookup = 8'b1000_0010;
            4'hA:    key_lookup = 8'b1000_0001;
            4'h4:    key_lookup = 8'b0100_1000;
            4'h5:    key_lookup = 8'b0100_0100;
            4'h6:    key_lookup = 8'b0100_0010;
            4'hB:    key_lookup = 8'b0100_0001;
            4'h7:    key_lookup = 8'b0010_1000;
            4'h8:    key_lookup = 8'b0010_0100;
            4'h9:    key_lookup = 8'b0010_0010;
            4'hC:    key_lookup = 8'b0010_0001;
            4'hE:    key_lookup = 8'b0001_1000;
            4'h0:    key_lookup = 8'b0001_0100;
            4'hF:    key_lookup = 8'b0001_0010;
            default: key_lookup = 8'b0001_0001;
        endcase
    endfunction

    assign key_map  = key_lookup(press_key);
    assign col_hit  = col & key_col_q;
    assign col_edge = (state_q == S_HOLD) && (col_hit != 4'b0000) && (col_prev_q == 4'b0000);

    always_comb begin
        state_d      = state_q;
        key_col_d    = key_col_q;
        key_row_d    = key_row_q;
        bounce_cnt_d = bounce_cnt_q + 16'd1;
        hold_cyc_d   = hold_cyc_q + 20'd1;
        scan_cnt_d   = scan_cnt_q;
        done_d       = 1'b0;
        timeout_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (press_valid && ready_q) begin
                    key_col_d = key_map[7:4];
                    key_row_d = key_map[3:0];
                    state_d   = (BOUNCE_CYCLES == 0) ? S_HOLD : S_BOUNCE_IN;
                end
            end
            S_BOUNCE_IN: begin
                if (bounce_cnt_q == BOUNCE_LAST) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (col_edge) begin
                    scan_cnt_d = scan_cnt_q + 16'd1;
                end
                // Release only once the final strobe has ended, so the scanner sees it whole.
                if ((scan_cnt_q >= SCANS_NEED) && (col_hit == 4'b0000)) begin
                    if (BOUNCE_CYCLES == 0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_BOUNCE_OUT;
                    end
                end else if (hold_cyc_q == HOLD_LAST) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                if (bounce_cnt_q == BOUNCE_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
        if (state_d != state_q) begin
            bounce_cnt_d = 16'd0;
            hold_cyc_d   = 20'd0;
            scan_cnt_d   = 16'd0;
        end
        // Sampled against the next key column so a strobe already high at HOLD entry is not an edge.
        col_prev_d = col & key_col_d;
    end

    always_comb begin
        contact = 1'b0;
        case (state_q)
            S_BOUNCE_IN:  contact = ~bounce_cnt_q[0];
            S_HOLD:       contact = 1'b1;
            S_BOUNCE_OUT: contact = bounce_cnt_q[0];
            default:      contact = 1'b0;
        endcase
    end

    assign filas       = (contact && (col_hit != 4'b0000)) ? key_row_q : 4'b0000;
    assign busy        = (state_q != S_IDLE);
    assign press_ready = ready_q;
    assign done        = done_q;
    assign timeout     = timeout_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            key_col_q    <= 4'b0000;
            key_row_q    <= 4'b0000;
            col_prev_q   <= 4'b0000;
            bounce_cnt_q <= 16'd0;
            hold_cyc_q   <= 20'd0;
            scan_cnt_q   <= 16'd0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_col_q    <= key_col_d;
            key_row_q    <= key_row_d;
            col_prev_q   <= col_prev_d;
            bounce_cnt_q <= bounce_cnt_d;
            hold_cyc_q   <= hold_cyc_d;
            scan_cnt_q   <= scan_cnt_d;
            ready_q      <= (state_d == S_IDLE);
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb/tb_keypad_emulator.sv - scoreboard bench for keypad_emulator with timeline reference model
module tb_keypad_emulator;

    localparam int B_A = 4;
    localparam int H_A = 2;
    localparam int T_A = 1048575;
    localparam int B_B = 0;
    localparam int H_B = 0;
    localparam int T_B = 50;

    typedef struct {
        int cyc;
        bit tmo;
        int key;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pv[2];
    logic [3:0] pk[2];
    logic [3:0] col[2];
    logic       ready[2];
    logic       busy[2];
    logic       done[2];
    logic       tmo[2];
    logic [3:0] filas[2];

    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    bit         after_rst = 1'b1;
    int         slen[2] = '{10, 5};
    logic [3:0] sval[2] = '{4'b0000, 4'b0000};
    int         codes[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    bit         p_act[2];
    bit         p_tmo[2];
    int         p_t0[2], p_h[2], p_e[2], p_end[2];
    logic [3:0] p_col[2], p_row[2];
    int         xfer_cnt[2] = '{0, 0};
    exp_t       sb[2][$];

    always #5 clk = ~clk;

    keypad_emulator #(.BOUNCE_CYCLES(B_A), .HOLD_SCANS(H_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .press_valid(pv[0]), .press_key(pk[0]),
        .press_ready(ready[0]), .col(col[0]), .filas(filas[0]), .busy(busy[0]),
        .done(done[0]), .timeout(tmo[0])
    );

    keypad_emulator #(.BOUNCE_CYCLES(B_B), .HOLD_SCANS(H_B), .TIMEOUT(T_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .press_valid(pv[1]), .press_key(pk[1]),
        .press_ready(ready[1]), .col(col[1]), .filas(filas[1]), .busy(busy[1]),
        .done(done[1]), .timeout(tmo[1])
    );

    function automatic logic [3:0] col_at(input int k, input int c);
        logic [3:0] first = 4'b1000;
        if (slen[k] == 0) return sval[k];
        return first >> ((c / slen[k]) % 4);
    endfunction

    function automatic bit hit(input int k, input int c);
        return (col_at(k, c) & p_col[k]) != 4'b0000;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, k, cyc, act, exp);
    endtask

    // Whole-press timeline from the key table and the known scanner schedule.
    task automatic start_press(input int k, input int c, input int key);
        int   b    = (k == 0) ? B_A : B_B;
        int   hs   = (k == 0) ? H_A : H_B;
        int   tl   = (k == 0) ? T_A : T_B;
        int   n    = 0;
        bit   fnd  = 0;
        logic [3:0] top = 4'b1000;
        exp_t e;
        if (hs == 0) hs = 1;
        for (int i = 0; i < 16; i++) begin
            if (codes[i] == key) begin
                p_col[k] = top >> (i / 4);
                p_row[k] = top >> (i % 4);
            end
        end
        p_act[k] = 1;
        p_t0[k]  = c + 1;
        p_h[k]   = c + 1 + b;
        for (int x = p_h[k]; x < p_h[k] + tl && !fnd; x++) begin
            if (n >= hs && !hit(k, x)) begin
                p_e[k] = x;
                fnd = 1;
            end else if (hit(k, x) && !hit(k, x - 1)) begin
                n++;
            end
        end
        p_tmo[k] = !fnd;
        p_end[k] = fnd ? (p_e[k] + b + 1) : (p_h[k] + tl);
        e.cyc = p_end[k];
        e.tmo = p_tmo[k];
        e.key = key;
        sb[k].push_back(e);
        xfer_cnt[k]++;
    endtask

    function automatic bit exp_ready(input int k, input int c);
        return !after_rst && !(p_act[k] && c < p_end[k]);
    endfunction

    function automatic logic [3:0] exp_filas(input int k, input int c);
        bit closed;
        if (c < p_h[k]) closed = ((c - p_t0[k]) % 2) == 0;
        else if (!p_tmo[k] && c > p_e[k]) closed = ((c - p_e[k] - 1) % 2) == 1;
        else closed = 1;
        return (closed && hit(k, c)) ? p_row[k] : 4'b0000;
    endfunction

    // Reference model: inputs seen at each edge, outputs compared mid-cycle.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                after_rst = 1;
                for (int k = 0; k < 2; k++) begin
                    p_act[k] = 0;
                    sb[k].delete();
                end
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (exp_ready(k, cyc) && pv[k]) start_press(k, cyc, int'(pk[k]));
                end
                after_rst = 0;
            end
            cyc++;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (after_rst || !(p_act[k] && cyc < p_end[k])) begin
                    check("ready", k, ready[k], !after_rst);
                    check("busy", k, busy[k], 0);
                    check("filas_idle", k, filas[k], 0);
                end else begin
                    check("ready", k, ready[k], 0);
                    check("busy", k, busy[k], 1);
                    check("filas", k, filas[k], exp_filas(k, cyc));
                end
            end
        end
    end

    // Scoreboard monitor: every done/timeout pulse must match the oldest expected press outcome.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                while (sb[k].size() > 0 && sb[k][0].cyc < cyc) begin
                    e = sb[k].pop_front();
                    n_checks++;
                    $display("FAIL missing_end dut%0d key=%0h got=none want_cyc=%0d", k, e.key, e.cyc);
                end
                if (done[k] || tmo[k]) begin
                    if (sb[k].size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_end dut%0d cyc=%0d got done=%0b timeout=%0b want=none", k, cyc, done[k], tmo[k]);
                    end else begin
                        e = sb[k].pop_front();
                        check("end_cycle", k, cyc, e.cyc);
                        check("end_kind", k, {30'd0, done[k], tmo[k]}, e.tmo ? 32'd1 : 32'd2);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            for (int k = 0; k < 2; k++) col[k] = col_at(k, cyc);
            @(posedge clk);
            #1;
        end
    end

    task automatic wait_xfer(input int k, input int start);
        int i = 0;
        while (xfer_cnt[k] == start && i < 3000) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (xfer_cnt[k] == start) begin
            n_checks++;
            $display("FAIL accept dut%0d got ready=%0b want transfer", k, ready[k]);
        end
    endtask

    task automatic press(input int k, input int key);
        int start = xfer_cnt[k];
        pv[k] = 1'b1;
        pk[k] = 4'(key);
        wait_xfer(k, start);
        pv[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int i = 0;
        while ((after_rst || (p_act[k] && cyc < p_end[k])) && i < 3000) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (i >= 3000) begin
            n_checks++;
            $display("FAIL idle dut%0d got busy=%0b want idle", k, busy[k]);
        end
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int start;
        int i;
        pv[0] = 1'b0; pv[1] = 1'b0;
        pk[0] = 4'h0; pk[1] = 4'h0;
        rst_n = 1'b0;
        gap(3);
        rst_n = 1'b1;
        gap(2);

        press(0, 5);  wait_idle(0);
        press(0, 13); wait_idle(0);
        press(0, 0);  wait_idle(0);

        // Held request during a press: only taken again once press_ready returns.
        start = xfer_cnt[0];
        pv[0] = 1'b1;
        pk[0] = 4'h1;
        wait_xfer(0, start);
        pk[0] = 4'h7;
        wait_xfer(0, start + 1);
        pv[0] = 1'b0;
        wait_idle(0);

        slen[1] = 0; sval[1] = 4'b0000;
        gap(3);
        press(1, int'($urandom_range(0, 15))); wait_idle(1);
        sval[1] = 4'b1111;
        gap(3);
        press(1, 9); wait_idle(1);

        press(0, 5);
        i = 0;
        while (!(p_act[0] && cyc >= p_h[0] && cyc <= p_e[0] && col[0] == 4'b0100) && i < 3000) begin
            gap(1);
            i++;
        end
        rst_n = 1'b0;
        gap(3);
        rst_n = 1'b1;
        gap(2);

        slen[1] = 5;
        gap(3);
        fork
            begin
                for (int n = 0; n < 8; n++) begin
                    press(0, int'($urandom_range(0, 15)));
                    wait_idle(0);
                    gap(int'($urandom_range(0, 6)));
                end
            end
            begin
                for (int n = 0; n < 12; n++) begin
                    press(1, int'($urandom_range(0, 15)));
                    wait_idle(1);
                    gap(int'($urandom_range(0, 6)));
                end
            end
        join
        gap(4);
        check("sb_empty", 0, sb[0].size(), 0);
        check("sb_empty", 1, sb[1].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL global_time got=running want=finished");
        $fatal(1, "bench time limit");
    end

endmodule
